instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage for the MIPS core, directly upstream of the instruction memory. It holds the PC, drives the word address into the combinational instruction ROM and registers the returned word into the IF/ID pipeline register. Redirects from the branch/jump resolver, stall and flush from the hazard unit, and a halt/fault state machine are handled here.

## Interface
- `RESET_PC`, 32'h00400000: PC after reset; also the base of the instruction ROM window.
- `ADDR_W`, 9: ROM word-address width; the window is 2^ADDR_W words.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `stall`  in  1: hold PC and IF/ID.
- `flush`  in  1: load a bubble into IF/ID.
- `redirect_valid`  in  1: taken branch/jump/jr this cycle.
- `redirect_pc`  in  32: byte target of the redirect.
- `imem_addr`  out  ADDR_W: word address to the ROM, equal to `(pc - RESET_PC) >> 2`, combinational from the PC register.
- `imem_dout`  in  32: ROM read data; same-cycle combinational.
- `pc`  out  32: current fetch PC.
- `ifid_valid`  out  1: IF/ID holds a real instruction.
- `ifid_instr`  out  32: fetched word; 0 (nop) when it holds a bubble.
- `ifid_pc`  out  32: PC of `ifid_instr`.
- `ifid_pc_plus4`  out  32: `ifid_pc + 4`.
- `halted`  out  1: self-loop detected.
- `fault`  out  1: illegal fetch target.
- `fault_pc`  out  32: offending target address.
- `fetch_count`  out  16: count of valid instructions captured; saturates at 16'hFFFF.

## Operation
- FSM states: RUN, HALT, FAULT. Reset enters RUN. Only reset leaves HALT or FAULT.
- Legal target: `t[1:0] == 0` and `RESET_PC <= t < RESET_PC + 4*2^ADDR_W`.
- RUN: per-cycle priority is reset, then redirect, then stall, then sequential.
  - Redirect with a legal target: PC loads `redirect_pc`. IF/ID takes a bubble (the wrong-path word is squashed). This applies regardless of `stall` or `flush`.
  - Redirect with an illegal target: go to FAULT, with `fault_pc = redirect_pc`. PC holds; IF/ID takes a bubble.
  - Otherwise, `stall=1`: PC holds.
    - `flush=1`: IF/ID takes a bubble.
    - `flush=0`: IF/ID holds.
  - Otherwise, sequential fetch.
    - If `pc+4` is illegal (end of window): go to FAULT, with `fault_pc = pc+4`. IF/ID still captures the current word (unless `flush`). PC holds.
    - Else PC becomes `pc+4`. IF/ID captures `{1, imem_dout, pc}`, or a bubble if `flush`.
  - Halt detection: a real capture (not a bubble) of 32'h1000ffff (`beq $0,$0,-1`) moves to HALT at the same edge. The word itself is still delivered once in IF/ID.
- HALT:
  - PC frozen; `redirect_valid`, `stall` and `flush` are ignored.
  - IF/ID takes a bubble on every edge after entry.
  - `halted=1`.
- FAULT: same as HALT, but `fault=1` and `halted=0`.
- `fetch_count` increments only on an edge where IF/ID captures a real instruction.
- Bubble contents: `ifid_valid=0`, `ifid_instr=0`, `ifid_pc=0`, `ifid_pc_plus4=4`.

## Timing
- Reset values:
  - `pc=RESET_PC`, so `imem_addr=0`.
  - IF/ID is a bubble.
  - `halted=0`, `fault=0`, `fault_pc=0`, `fetch_count=0`.
- Latency: a word at PC p appears in `ifid_instr` one edge after p is presented on `imem_addr`. Back-to-back, one instruction per cycle.
- A redirect asserted in cycle n puts its target on `imem_addr` in cycle n+1. The target's word appears in IF/ID after the n+2 edge. Exactly one bubble is inserted.
- Stall produces no bubble; the same IF/ID contents are held for every stalled cycle.
- Reset asserted mid-stream overrides everything on that edge, including redirect, stall and FSM state.
- All outputs are registered except `imem_addr`, which is combinational from the `pc` register.

## Test plan
- Reset then run 3 cycles:
  - `ifid_instr` sequence 32'h3c011001 (pc 0x00400000), then 32'h343a0000 (pc 0x00400004).
  - `fetch_count=2`, `imem_addr=2`.
- Redirect to 0x004001C8 in cycle n:
  - `imem_addr=0x72` in n+1.
  - Bubble in IF/ID after n+1.
  - `ifid_instr=32'hafdf02d8`, `ifid_pc=0x004001C8` after n+2.
- Stall for 3 cycles, with flush asserted in cycle 2 and redirect in cycle 3:
  - PC holds across the stall.
  - IF/ID holds, then takes a bubble.
  - The redirect is still taken despite `stall`; `fetch_count` is unchanged.
- Run to word 20 (returns 32'h1000ffff):
  - That word is delivered once, then `halted=1`.
  - PC stays at 0x00400054.
  - A later redirect is ignored; IF/ID shows bubbles.
- Redirect to 0x00400002 (misaligned):
  - `fault=1`, `fault_pc=0x00400002`.
- Separately, redirect to 0x00400800 (out of range):
  - `fault=1`, `fault_pc=0x00400800`.
- Redirect to 0x004007FC then run sequentially:
  - The word at 0x1FF is delivered.
  - Then `fault=1` with `fault_pc=0x00400800`.
- Reset asserted during FAULT: all outputs return to their reset values.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: hazard/redirect controls in, ROM port, IF/ID register and status out.
// The master side is the fetch stage; the slave side is its environment (ROM, hazard unit, decode).
interface instruction_fetch_if #(
    parameter int ADDR_W = 9
);
    logic                stall;
    logic                flush;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic [ADDR_W-1:0]   imem_addr;
    logic [31:0]         imem_dout;
    logic [31:0]         pc;
    logic                ifid_valid;
    logic [31:0]         ifid_instr;
    logic [31:0]         ifid_pc;
    logic [31:0]         ifid_pc_plus4;
    logic                halted;
    logic                fault;
    logic [31:0]         fault_pc;
    logic [15:0]         fetch_count;

    modport master (
        input  stall, flush, redirect_valid, redirect_pc, imem_dout,
        output imem_addr, pc, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4,
               halted, fault, fault_pc, fetch_count
    );

    modport slave (
        output stall, flush, redirect_valid, redirect_pc, imem_dout,
        input  imem_addr, pc, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4,
               halted, fault, fault_pc, fetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS instruction-fetch stage: PC register, ROM word addressing, IF/ID register,
// redirect/stall/flush handling and a RUN/HALT/FAULT state machine.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          ADDR_W   = 9
) (
    input logic                 clk,
    input logic                 reset,
    instruction_fetch_if.master bus
);
    localparam logic [31:0] HALT_WORD = 32'h1000_ffff;

    typedef enum logic [1:0] {RUN, HALT, FAULT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [15:0] count_q, count_d;
    logic [31:0] pc_plus4;
    logic        load_bubble;
    logic        load_word;

    // Word-aligned and inside the ROM window; targets below the base fail the >= test.
    function automatic logic legal_target(input logic [31:0] t);
        logic [31:0] off;
        off = t - RESET_PC;
        return (t[1:0] == 2'b00) && (t >= RESET_PC) && ((off >> (ADDR_W + 2)) == 32'd0);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fault_pc_d  = fault_pc_q;
        load_bubble = 1'b0;
        load_word   = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.redirect_valid) begin
                    // The word fetched this cycle is wrong-path, whatever stall/flush say.
                    load_bubble = 1'b1;
                    if (legal_target(bus.redirect_pc)) begin
                        pc_d = bus.redirect_pc;
                    end else begin
                        state_d    = FAULT;
                        fault_pc_d = bus.redirect_pc;
                    end
                end else if (bus.stall) begin
                    load_bubble = bus.flush;
                end else begin
                    load_bubble = bus.flush;
                    load_word   = !bus.flush;
                    if (!legal_target(pc_plus4)) begin
                        state_d    = FAULT;
                        fault_pc_d = pc_plus4;
                    end else begin
                        pc_d = pc_plus4;
                        if (!bus.flush && bus.imem_dout == HALT_WORD) begin
                            state_d = HALT;
                        end
                    end
                end
            end
            default: load_bubble = 1'b1;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        count_d = count_q;
        if (load_bubble) begin
            valid_d = 1'b0;
            instr_d = 32'd0;
            ipc_d   = 32'd0;
            ipc4_d  = 32'd4;
        end else if (load_word) begin
            valid_d = 1'b1;
            instr_d = bus.imem_dout;
            ipc_d   = pc_q;
            ipc4_d  = pc_plus4;
            count_d = sat_inc16(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= 32'd0;
            ipc_q      <= 32'd0;
            ipc4_q     <= 32'd4;
            fault_pc_q <= 32'd0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
            ipc4_q     <= ipc4_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    assign bus.imem_addr     = ADDR_W'((pc_q - RESET_PC) >> 2);
    assign bus.pc            = pc_q;
    assign bus.ifid_valid    = valid_q;
    assign bus.ifid_instr    = instr_q;
    assign bus.ifid_pc       = ipc_q;
    assign bus.ifid_pc_plus4 = ipc4_q;
    assign bus.halted        = (state_q == HALT);
    assign bus.fault         = (state_q == FAULT);
    assign bus.fault_pc      = fault_pc_q;
    assign bus.fetch_count   = count_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table plus hand-written fault/reset sequences,
// expected post-edge state queued at drive time and compared one step later.
module tb_instruction_fetch;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam int          ADDR_W   = 9;

    typedef struct {
        int          id;
        logic        rst;
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        halted;
        logic        fault;
        logic [31:0] fpc;
        logic [15:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    instruction_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_fetch #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [ADDR_W-1:0] a);
        case (a)
            9'd0:    return 32'h3c01_1001;
            9'd1:    return 32'h343a_0000;
            9'd20:   return 32'h1000_ffff;
            9'd114:  return 32'hafdf_02d8;
            default: return 32'h2400_0000 | 32'(a);
        endcase
    endfunction

    assign bus.imem_dout = rom(bus.imem_addr);

    function automatic logic [31:0] P(input int n);
        return RESET_PC + 32'(4 * n);
    endfunction

    function automatic vec_t mk(input int id, input logic rst, input logic st, input logic fl,
                                input logic rv, input logic [31:0] rpc, input logic [31:0] pc,
                                input logic valid, input logic [31:0] instr, input logic [31:0] ipc,
                                input logic h, input logic f, input logic [31:0] fpc,
                                input logic [15:0] cnt);
        vec_t v;
        v.id = id; v.rst = rst; v.stall = st; v.flush = fl; v.rv = rv; v.rpc = rpc;
        v.pc = pc; v.valid = valid; v.instr = instr; v.ipc = ipc;
        v.halted = h; v.fault = f; v.fpc = fpc; v.cnt = cnt;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        vec_t              e;
        logic [31:0]       p4;
        logic [ADDR_W-1:0] ea;
        reset              = v.rst;
        bus.stall          = v.stall;
        bus.flush          = v.flush;
        bus.redirect_valid = v.rv;
        bus.redirect_pc    = v.rpc;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e  = exp_q.pop_front();
        p4 = e.valid ? e.ipc + 32'd4 : 32'd4;
        ea = ADDR_W'((e.pc - RESET_PC) >> 2);
        checks++;
        if (bus.pc === e.pc && bus.imem_addr === ea && bus.ifid_valid === e.valid &&
            bus.ifid_instr === e.instr && bus.ifid_pc === e.ipc && bus.ifid_pc_plus4 === p4 &&
            bus.halted === e.halted && bus.fault === e.fault && bus.fault_pc === e.fpc &&
            bus.fetch_count === e.cnt) begin
            passed++;
        end else begin
            $display("FAIL vec%0d: got pc=%h addr=%h v=%b instr=%h ipc=%h p4=%h h=%b f=%b fpc=%h cnt=%0d | want pc=%h addr=%h v=%b instr=%h ipc=%h p4=%h h=%b f=%b fpc=%h cnt=%0d",
                     e.id, bus.pc, bus.imem_addr, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc,
                     bus.ifid_pc_plus4, bus.halted, bus.fault, bus.fault_pc, bus.fetch_count,
                     e.pc, ea, e.valid, e.instr, e.ipc, p4, e.halted, e.fault, e.fpc, e.cnt);
        end
    endtask

    initial begin
        // Reset, two sequential words, redirect, stall/flush/redirect, then run into the halt word.
        tbl.push_back(mk(0,  1,0,0,0,32'd0,        P(0),        0,32'd0,         32'd0,       0,0,32'd0,0));
        tbl.push_back(mk(1,  0,0,0,0,32'd0,        P(1),        1,32'h3c011001,  P(0),        0,0,32'd0,1));
        tbl.push_back(mk(2,  0,0,0,0,32'd0,        P(2),        1,32'h343a0000,  P(1),        0,0,32'd0,2));
        tbl.push_back(mk(3,  0,0,0,1,32'h004001C8, 32'h004001C8,0,32'd0,         32'd0,       0,0,32'd0,2));
        tbl.push_back(mk(4,  0,0,0,0,32'd0,        32'h004001CC,1,32'hafdf02d8,  32'h004001C8,0,0,32'd0,3));
        tbl.push_back(mk(5,  0,0,0,0,32'd0,        32'h004001D0,1,32'h24000073,  32'h004001CC,0,0,32'd0,4));
        tbl.push_back(mk(6,  0,1,0,0,32'd0,        32'h004001D0,1,32'h24000073,  32'h004001CC,0,0,32'd0,4));
        tbl.push_back(mk(7,  0,1,1,0,32'd0,        32'h004001D0,0,32'd0,         32'd0,       0,0,32'd0,4));
        tbl.push_back(mk(8,  0,1,0,1,P(10),        P(10),       0,32'd0,         32'd0,       0,0,32'd0,4));
        tbl.push_back(mk(9,  0,0,0,0,32'd0,        P(11),       1,32'h2400000a,  P(10),       0,0,32'd0,5));
        tbl.push_back(mk(10, 0,0,1,0,32'd0,        P(12),       0,32'd0,         32'd0,       0,0,32'd0,5));
        for (int k = 11; k <= 18; k++) begin
            tbl.push_back(mk(k, 0,0,0,0,32'd0, P(k+2), 1, 32'h24000000 | 32'(k+1), P(k+1),
                             0,0,32'd0,16'(k-5)));
        end
        tbl.push_back(mk(19, 0,0,0,0,32'd0,        P(21),       1,32'h1000ffff,  P(20),       1,0,32'd0,14));
        tbl.push_back(mk(20, 0,0,0,0,32'd0,        P(21),       0,32'd0,         32'd0,       1,0,32'd0,14));
        tbl.push_back(mk(21, 0,0,0,1,RESET_PC,     P(21),       0,32'd0,         32'd0,       1,0,32'd0,14));
        tbl.push_back(mk(22, 0,1,1,1,32'h00400100, P(21),       0,32'd0,         32'd0,       1,0,32'd0,14));
        foreach (tbl[i]) apply(tbl[i]);

        // Reset beats redirect/stall; misaligned target faults; reset clears FAULT.
        apply(mk(100, 1,1,0,1,32'h00400100, P(0),0,32'd0,32'd0,0,0,32'd0,0));
        apply(mk(101, 0,0,0,1,32'h00400002, P(0),0,32'd0,32'd0,0,1,32'h00400002,0));
        apply(mk(102, 0,0,0,0,32'd0,        P(0),0,32'd0,32'd0,0,1,32'h00400002,0));
        apply(mk(103, 1,0,0,0,32'd0,        P(0),0,32'd0,32'd0,0,0,32'd0,0));
        // Targets just past the window and just below the base.
        apply(mk(104, 0,0,0,1,32'h00400800, P(0),0,32'd0,32'd0,0,1,32'h00400800,0));
        apply(mk(105, 1,0,0,0,32'd0,        P(0),0,32'd0,32'd0,0,0,32'd0,0));
        apply(mk(106, 0,1,0,1,32'h003FFFFC, P(0),0,32'd0,32'd0,0,1,32'h003FFFFC,0));
        apply(mk(107, 1,0,0,0,32'd0,        P(0),0,32'd0,32'd0,0,0,32'd0,0));
        // Last word of the window is delivered, then sequential fetch faults.
        apply(mk(108, 0,0,0,1,32'h004007FC, 32'h004007FC,0,32'd0,       32'd0,       0,0,32'd0,0));
        apply(mk(109, 0,0,0,0,32'd0,        32'h004007FC,1,32'h240001ff,32'h004007FC,0,1,32'h00400800,1));
        apply(mk(110, 0,0,0,0,32'd0,        32'h004007FC,0,32'd0,       32'd0,       0,1,32'h00400800,1));
        apply(mk(111, 1,0,0,0,32'd0,        P(0),0,32'd0,32'd0,0,0,32'd0,0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
